immediate_fetch_unit: RTL and testbench
=======================================

# immediate_fetch_unit

Parametrised successor to the 8/16-bit immediate reader. Pops 0..MAX_BYTES little-endian bytes from the instruction prefetch FIFO and assembles them into a MAX_BYTES-wide immediate or displacement, zero- or sign-extended per request. Adds flush/abort, per-request length, runtime extension mode and stall tolerance. Sits between the prefetch FIFO read port and the decoder/microcode immediate latch.

## Interface
- MAX_BYTES, 4: maximum bytes per request (≥1); OUT_W = 8*MAX_BYTES.
- CNT_W, $clog2(MAX_BYTES+1): width of byte counts.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; accepted only when busy is low, or in the complete cycle.
- num_bytes  in  CNT_W  bytes to read; sampled on accepted start.
- sign_extend  in  1  1 = sign-extend from the MSB of the last byte, 0 = zero-extend; sampled on accepted start.
- flush  in  1  synchronous abort (branch/interrupt redirect).
- busy  out  1  start | (state != IDLE && !complete).
- complete  out  1  one-cycle pulse; immediate valid from this cycle.
- immediate  out  OUT_W  assembled, extended value; held until the next complete.
- fifo_rd_en  out  1  FIFO pop.
- fifo_rd_data  in  8  FIFO data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty.

## Operation
- States: IDLE, FETCH, DONE.
- IDLE→FETCH on accepted start with n≥1. IDLE→DONE on start with n=0.
- FETCH→DONE when received == n.
- DONE→IDLE, or DONE→FETCH/DONE on a same-cycle start.
- Effective n = min(num_bytes, MAX_BYTES), latched at start with sign_extend.
- issued counter (CNT_W) increments per fifo_rd_en. received counter increments per popped byte (popped = registered fifo_rd_en).
- fifo_rd_en = reset_n & ~fifo_empty & ~flush & (accepted start | (FETCH & issued < n)).
- The accepted-start cycle pops with issued = 0.
- Byte k (0-based arrival order) is written to assembly bits [8k+7:8k].
- When entering DONE, bits above 8n are filled with {byte[n-1][7]} if sign_extend, else 0. The result is written to the immediate register.
- n = 0 gives immediate = 0.
- fifo_empty mid-request: rd_en low, state held. Resumes when data is present; no bytes lost or duplicated.
- flush in any state: next state IDLE. Counters are cleared and no complete is issued. A byte popped in the previous cycle is discarded. immediate keeps its last completed value. flush + start in the same cycle: flush wins, start is ignored.
- start while busy (other than the complete cycle): ignored, no pop.
- Reset (asynchronous, any time): state IDLE, counters 0, immediate 0, complete 0, busy 0, fifo_rd_en 0 while reset_n is low.

## Timing
- Start in cycle 0, FIFO never empty, n≥1: rd_en high in cycles 0..n-1. Bytes arrive in cycles 1..n. complete and new immediate appear in cycle n+1 (registered).
- n = 0: complete in cycle 1, no pops.
- Each empty cycle during fetch adds exactly one cycle of latency.
- Back-to-back: start in the complete cycle pops in that same cycle. Sustained throughput is n+1 cycles per request.
- busy is high from the start cycle (combinational) until the cycle before complete, and low during complete.
- complete is never asserted in two consecutive cycles unless n = 0 requests are back-to-back.

## Structure
- Package imm_fetch_pkg: state enum typedef (IDLE/FETCH/DONE) and a CNT_W helper function.
- Sub-module imm_extend: combinational; assembly buffer, n and sign_extend in; extended OUT_W value out. Parametrised on MAX_BYTES.
- Top level holds the FSM, both counters, the popped flag, the assembly buffer and the output register.

## Test plan
- MAX_BYTES=4, FIFO preloaded 0x78,0x56,0x34,0x12, n=4, start at cycle 0 → rd_en cycles 0–3, complete cycle 5, immediate=0x12345678.
- n=1, byte 0x80, sign_extend=1 → 0xFFFFFF80. Repeat with sign_extend=0 → 0x00000080.
- n=2, bytes 0xFE,0xFF, FIFO empty for 3 cycles after the first pop, sign_extend=1 → complete delayed 3 cycles, immediate=0xFFFFFFFE, exactly 2 pops.
- n=3 request, flush in cycle 2 → no complete, pops stop, immediate unchanged. A following n=1 start with byte 0x05 gives 0x00000005.
- Back-to-back: n=2 (0x34,0x12), start asserted in its complete cycle for n=0, then n=1 (0x7F) → completes give 0x1234, 0x0, then 0x7F, with no idle gap between requests.
- reset_n pulsed low mid-fetch → all outputs 0 immediately. After release, start with n=1 works normally.

Source files
------------

// File: rtl/imm_fetch_pkg.sv
// imm_fetch_pkg: FSM state type and byte-count width helper for the immediate fetch unit
package imm_fetch_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
   function automatic int cnt_width(input int max_bytes);
      return $clog2(max_bytes + 1);
   endfunction
endpackage

// File: rtl/imm_extend.sv
// imm_extend: zero/sign-extends the low n bytes of asm_buf to the full width (asm_buf, n, sign_extend in; ext out)
module imm_extend
   import imm_fetch_pkg::*;
#(
   parameter int MAX_BYTES = 4,
   parameter int CNT_W = cnt_width(MAX_BYTES)
) (
   input  logic [8*MAX_BYTES-1:0] asm_buf,
   input  logic [CNT_W-1:0]       n,
   input  logic                   sign_extend,
   output logic [8*MAX_BYTES-1:0] ext
);
   logic fill;
   always_comb begin
      fill = 1'b0;
      for (int k = 0; k < MAX_BYTES; k++)
         if (n == CNT_W'(k + 1)) fill = sign_extend & asm_buf[8*k+7];
   end
   genvar i;
   generate
      for (i = 0; i < MAX_BYTES; i++) begin : g_byte
         assign ext[8*i +: 8] = (CNT_W'(i) < n) ? asm_buf[8*i +: 8] : {8{fill}};
      end
   endgenerate
endmodule

// File: rtl/immediate_fetch_unit.sv
// immediate_fetch_unit: pops n little-endian FIFO bytes into an extended immediate (start/num_bytes/sign_extend/flush in; busy/complete/immediate out; fifo_rd_en/fifo_rd_data/fifo_empty FIFO port)
module immediate_fetch_unit
   import imm_fetch_pkg::*;
#(
   parameter int MAX_BYTES = 4,
   parameter int CNT_W = cnt_width(MAX_BYTES)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [CNT_W-1:0]       num_bytes,
   input  logic                   sign_extend,
   input  logic                   flush,
   output logic                   busy,
   output logic                   complete,
   output logic [8*MAX_BYTES-1:0] immediate,
   output logic                   fifo_rd_en,
   input  logic [7:0]             fifo_rd_data,
   input  logic                   fifo_empty
);
   localparam int OUT_W = 8*MAX_BYTES;
   state_t state, state_d;
   logic [CNT_W-1:0] n_q, n_eff, issued, received, received_d;
   logic sext_q, popped, accept;
   logic [OUT_W-1:0] asm_q, asm_d, ext;
   assign n_eff = (num_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : num_bytes;
   // DONE accepts a new start so back-to-back requests have no idle gap
   assign accept = start & ~flush & (state != FETCH);
   assign fifo_rd_en = reset_n & ~fifo_empty & ~flush &
                       ((accept & (n_eff != '0)) | ((state == FETCH) & (issued < n_q)));
   assign complete = (state == DONE);
   assign busy = reset_n & (start | (state == FETCH));
   assign received_d = received + CNT_W'(popped);
   always_comb begin
      asm_d = asm_q;
      for (int k = 0; k < MAX_BYTES; k++)
         if (popped && received == CNT_W'(k)) asm_d[8*k +: 8] = fifo_rd_data;
   end
   imm_extend #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) u_ext (
      .asm_buf(asm_d),
      .n(n_q),
      .sign_extend(sext_q),
      .ext(ext)
   );
   always_comb begin
      state_d = flush ? IDLE :
                accept ? ((n_eff == '0) ? DONE : FETCH) :
                (state == DONE) ? IDLE :
                ((state == FETCH) && (received_d == n_q)) ? DONE : state;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_d;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_q <= '0;
         sext_q <= 1'b0;
         issued <= '0;
         received <= '0;
         popped <= 1'b0;
         asm_q <= '0;
         immediate <= '0;
      end else begin
         popped <= fifo_rd_en;
         if (flush) begin
            issued <= '0;
            received <= '0;
         end else if (accept) begin
            n_q <= n_eff;
            sext_q <= sign_extend;
            issued <= CNT_W'(fifo_rd_en);
            received <= '0;
            asm_q <= '0;
            if (n_eff == '0) immediate <= '0;
         end else if (state == FETCH) begin
            issued <= issued + CNT_W'(fifo_rd_en);
            received <= received_d;
            asm_q <= asm_d;
            if (state_d == DONE) immediate <= ext;
         end
      end
   end
endmodule

// File: tb/tb_immediate_fetch_unit.sv
// tb_immediate_fetch_unit: directed vectors with a completion scoreboard for immediate_fetch_unit
module tb_immediate_fetch_unit;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, sign_extend = 1'b0, flush = 1'b0;
   logic fifo_empty, fifo_rd_en, busy, complete, fifo_clr = 1'b0;
   logic [2:0] num_bytes = '0;
   logic [7:0] fifo_rd_data = '0;
   logic [31:0] immediate;
   logic [7:0] mem [0:63];
   int wr_ptr = 0, rd_ptr = 0, cyc = 0, pops = 0, p0 = 0, n_vec = 0, n_err = 0;
   typedef struct {logic [31:0] v; int c;} exp_t;
   exp_t exp_q[$];

   immediate_fetch_unit #(.MAX_BYTES(4)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .num_bytes(num_bytes),
      .sign_extend(sign_extend),
      .flush(flush),
      .busy(busy),
      .complete(complete),
      .immediate(immediate),
      .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data),
      .fifo_empty(fifo_empty)
   );

   always #5 clk = ~clk;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_clr) rd_ptr <= wr_ptr;
      else if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
         pops <= pops + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   always @(negedge clk)
      if (reset_n && complete) begin : mon
         exp_t e;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_complete: got imm %h at cycle %0d expected none", immediate, cyc);
         end else begin
            e = exp_q.pop_front();
            check("immediate", immediate, e.v);
            check("complete_cycle", cyc, e.c);
         end
      end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_done(input logic [31:0] v, input int lat);
      exp_q.push_back(exp_t'{v, cyc + lat});
   endtask

   task automatic req(input logic [2:0] n, input logic sx, input logic [31:0] expv, input int lat);
      step();
      start = 1'b1;
      num_bytes = n;
      sign_extend = sx;
      expect_done(expv, lat);
      step();
      start = 1'b0;
      repeat (lat) step();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_complete", complete, 0);
      check("rst_imm", immediate, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      step();
      reset_n = 1'b1;
      // four-byte read, cycle-exact pop and busy windows
      push(8'h78); push(8'h56); push(8'h34); push(8'h12);
      step();
      start = 1'b1; num_bytes = 3'd4; sign_extend = 1'b0;
      expect_done(32'h12345678, 5);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t1_rd_en", fifo_rd_en, i < 4);
         check("t1_busy", busy, i < 5);
         step();
         start = 1'b0;
      end
      // num_bytes above MAX_BYTES clamps to 4
      push(8'h01); push(8'h02); push(8'h03); push(8'h84);
      req(3'd7, 1'b1, 32'h84030201, 5);
      // single byte sign / zero extension
      push(8'h80); req(3'd1, 1'b1, 32'hFFFFFF80, 2);
      push(8'h80); req(3'd1, 1'b0, 32'h00000080, 2);
      // FIFO empty three cycles after the first pop
      p0 = pops;
      push(8'hFE);
      step();
      start = 1'b1; num_bytes = 3'd2; sign_extend = 1'b1;
      expect_done(32'hFFFFFFFE, 6);
      repeat (4) begin step(); start = 1'b0; end
      push(8'hFF);
      repeat (3) step();
      check("t3_pops", pops - p0, 2);
      // flush mid-request
      p0 = pops;
      push(8'hAA); push(8'hBB); push(8'hCC);
      step();
      start = 1'b1; num_bytes = 3'd3; sign_extend = 1'b0;
      step();
      start = 1'b0;
      step();
      flush = 1'b1;
      @(negedge clk);
      check("t4_rd_en_flush", fifo_rd_en, 0);
      step();
      flush = 1'b0;
      @(negedge clk);
      check("t4_busy", busy, 0);
      check("t4_imm_held", immediate, 32'hFFFFFFFE);
      repeat (4) step();
      check("t4_pops", pops - p0, 2);
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
      push(8'h05); req(3'd1, 1'b0, 32'h00000005, 2);
      // back-to-back: n=2, then n=0 in its complete cycle, then n=1
      push(8'h34); push(8'h12); push(8'h7F);
      step();
      start = 1'b1; num_bytes = 3'd2; sign_extend = 1'b0;
      expect_done(32'h00001234, 3);
      step();
      start = 1'b0;
      step();
      step();
      start = 1'b1; num_bytes = 3'd0; sign_extend = 1'b1;
      expect_done(32'h00000000, 1);
      @(negedge clk);
      check("t5_no_pop_n0", fifo_rd_en, 0);
      step();
      num_bytes = 3'd1; sign_extend = 1'b0;
      expect_done(32'h0000007F, 2);
      @(negedge clk);
      check("t5_b2b_pop", fifo_rd_en, 1);
      step();
      start = 1'b0;
      repeat (2) step();
      // asynchronous reset mid-fetch
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      step();
      start = 1'b1; num_bytes = 3'd4; sign_extend = 1'b0;
      step();
      start = 1'b0;
      step();
      reset_n = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_complete", complete, 0);
      check("t6_imm", immediate, 0);
      check("t6_rd_en", fifo_rd_en, 0);
      step();
      step();
      reset_n = 1'b1;
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
      push(8'h5A); req(3'd1, 1'b0, 32'h0000005A, 2);
      repeat (3) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
